// File: rtl/otter_iobus_timer.sv
// OTTER IOBUS timer peripheral.
// The timer has a 16-byte register window: CTRL, COUNT, COMPARE and STATUS.
// It has a prescaled 32-bit up-counter with a compare match.
// On each match it sends a one-cycle interrupt pulse to the MCU.
module otter_iobus_timer #(
    parameter logic [31:0] BASE_ADDR  = 32'h1100_0100,
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    output logic        INTR
);

    // Register state
    logic                  ctrl_en;
    logic                  ctrl_auto;
    logic                  ctrl_irq;
    logic [PRESCALE_W-1:0] ctrl_prescale;
    logic [31:0]           count;
    logic [31:0]           compare;
    logic                  match;
    logic [PRESCALE_W-1:0] psc;
    logic                  intr_q;

    // Address decode; the byte-lane bits play no part in selection
    logic       sel;
    logic [1:0] off;
    logic       unused_addr_bits;

    assign sel              = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
    assign off              = IOBUS_ADDR[3:2];
    assign unused_addr_bits = ^IOBUS_ADDR[1:0];

    logic wr_ctrl, wr_count, wr_compare, wr_status;

    assign wr_ctrl    = IOBUS_WR && sel && (off == 2'd0);
    assign wr_count   = IOBUS_WR && sel && (off == 2'd1);
    assign wr_compare = IOBUS_WR && sel && (off == 2'd2);
    assign wr_status  = IOBUS_WR && sel && (off == 2'd3);

    // A CTRL store that clears EN cancels a tick that would land on the same edge
    logic tick, hit;

    assign tick = ctrl_en && (psc == ctrl_prescale) && !(wr_ctrl && !IOBUS_OUT[0]);
    assign hit  = tick && (count == compare);

    // Combinational read mux; reads outside the window return zero
    always_comb begin
        IOBUS_IN = '0;
        if (sel) begin
            case (off)
                2'd0: begin
                    IOBUS_IN[0]                 = ctrl_en;
                    IOBUS_IN[1]                 = ctrl_auto;
                    IOBUS_IN[2]                 = ctrl_irq;
                    IOBUS_IN[16 +: PRESCALE_W]  = ctrl_prescale;
                end
                2'd1:    IOBUS_IN = count;
                2'd2:    IOBUS_IN = compare;
                default: IOBUS_IN[0] = match;
            endcase
        end
    end

    // CTRL register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ctrl_en       <= 1'b0;
            ctrl_auto     <= 1'b0;
            ctrl_irq      <= 1'b0;
            ctrl_prescale <= '0;
        end else if (wr_ctrl) begin
            ctrl_en       <= IOBUS_OUT[0];
            ctrl_auto     <= IOBUS_OUT[1];
            ctrl_irq      <= IOBUS_OUT[2];
            ctrl_prescale <= IOBUS_OUT[16 +: PRESCALE_W];
        end
    end

    // The prescaler restarts on any CTRL or COUNT store so that new settings take effect from a clean phase
    always_ff @(posedge CLK) begin
        if (RESET)
            psc <= '0;
        else if (wr_ctrl || wr_count || !ctrl_en || tick)
            psc <= '0;
        else
            psc <= psc + PRESCALE_W'(1);
    end

    // COUNT: a CPU store beats the tick increment or reload
    always_ff @(posedge CLK) begin
        if (RESET)
            count <= '0;
        else if (wr_count)
            count <= IOBUS_OUT;
        else if (tick)
            count <= (hit && ctrl_auto) ? '0 : count + 32'd1;
    end

    // COMPARE: a store on a tick edge only affects later comparisons
    always_ff @(posedge CLK) begin
        if (RESET)
            compare <= '0;
        else if (wr_compare)
            compare <= IOBUS_OUT;
    end

    // MATCH flag: a new match wins over a write-1-to-clear on the same edge
    always_ff @(posedge CLK) begin
        if (RESET)
            match <= 1'b0;
        else if (hit)
            match <= 1'b1;
        else if (wr_status && IOBUS_OUT[0])
            match <= 1'b0;
    end

    // One-cycle interrupt pulse for every match event while IRQ_EN is set
    always_ff @(posedge CLK) begin
        if (RESET)
            intr_q <= 1'b0;
        else
            intr_q <= hit && ctrl_irq;
    end

    assign INTR = intr_q;

endmodule

// File: tb/tb_otter_iobus_timer.sv
// Self-checking bench for otter_iobus_timer.
// The bench uses directed scenarios plus randomized register traffic.
// All results are checked against a behavioural reference model kept in the bench.
module tb_otter_iobus_timer;

    localparam logic [31:0] BASE = 32'h1100_0100;

    logic        CLK;
    logic        RESET;
    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic [31:0] IOBUS_IN;
    logic        INTR;

    int errors = 0;
    int checks = 0;

    otter_iobus_timer #(
        .BASE_ADDR  (BASE),
        .PRESCALE_W (16)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .IOBUS_ADDR (IOBUS_ADDR),
        .IOBUS_OUT  (IOBUS_OUT),
        .IOBUS_WR   (IOBUS_WR),
        .IOBUS_IN   (IOBUS_IN),
        .INTR       (INTR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ---------------- reference model ----------------
    // The model holds the architectural register state.
    // It also tracks the number of cycles elapsed since the tick period last restarted.
    bit          m_en, m_auto, m_irq, m_match, m_intr;
    int unsigned m_pre;
    int unsigned m_elapsed;
    bit [31:0]   m_count, m_cmp;

    function automatic void m_step(input bit rst, input bit wr, input bit [31:0] addr, input bit [31:0] data);
        bit        in_win, evt, tk;
        int unsigned o;
        bit [31:0] nc;
        if (rst) begin
            m_en = 0; m_auto = 0; m_irq = 0; m_pre = 0; m_count = 0; m_cmp = 0;
            m_match = 0; m_elapsed = 0; m_intr = 0;
            return;
        end
        in_win = (addr >> 4) == (BASE >> 4);
        o      = (addr >> 2) & 3;
        tk     = m_en && (m_elapsed == m_pre) && !(wr && in_win && o == 0 && data[0] == 1'b0);
        evt    = tk && (m_count == m_cmp);
        nc     = m_count;
        if (tk) nc = (evt && m_auto) ? 32'd0 : m_count + 32'd1;
        if (wr && in_win && o == 3 && data[0]) m_match = 0;
        if (evt) m_match = 1;
        m_intr = evt && m_irq;
        if ((wr && in_win && (o == 0 || o == 1)) || !m_en || tk) m_elapsed = 0;
        else m_elapsed = m_elapsed + 1;
        m_count = nc;
        if (wr && in_win) begin
            case (o)
                0: begin
                    m_en = data[0]; m_auto = data[1]; m_irq = data[2]; m_pre = data[31:16];
                end
                1: m_count = data;
                2: m_cmp = data;
                default: ;
            endcase
        end
    endfunction

    function automatic bit [31:0] m_read(input bit [31:0] addr);
        if ((addr >> 4) != (BASE >> 4)) return 32'h0;
        case ((addr >> 2) & 3)
            0: return (m_pre << 16) | (32'(m_irq) << 2) | (32'(m_auto) << 1) | 32'(m_en);
            1: return m_count;
            2: return m_cmp;
            default: return 32'(m_match);
        endcase
    endfunction

    // ---------------- bus drivers ----------------
    // One clock cycle with the given bus inputs; the model advances on the same edge
    task automatic do_cycle(input bit rst, input bit wr, input bit [31:0] addr, input bit [31:0] data);
        RESET      = rst;
        IOBUS_WR   = wr;
        IOBUS_ADDR = addr;
        IOBUS_OUT  = data;
        @(posedge CLK);
        m_step(rst, wr, addr, data);
        #1;
        RESET    = 1'b0;
        IOBUS_WR = 1'b0;
        IOBUS_OUT = 32'h0;
    endtask

    task automatic idle();
        do_cycle(0, 0, 32'h0, 32'h0);
    endtask

    task automatic rd(input bit [31:0] addr, output bit [31:0] v);
        IOBUS_WR   = 1'b0;
        IOBUS_ADDR = addr;
        #1;
        v = IOBUS_IN;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bit [31:0] v;
        do_cycle(1, 0, 32'h0, 32'h0);
        do_cycle(1, 0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            rd(BASE + 32'(i * 4), v);
            checks++;
            if (v !== 32'h0) begin
                errors++;
                $display("FAIL reset_read off%0d: got %h expected %h", i, v, 32'h0);
            end
        end
        checks++;
        if (INTR !== 1'b0) begin
            errors++;
            $display("FAIL reset_intr: got %b expected 0", INTR);
        end
        do_cycle(0, 1, BASE + 32'd8, 32'h1234_5678);
        rd(BASE + 32'd8, v);
        checks++;
        if (v !== 32'h1234_5678) begin
            errors++;
            $display("FAIL compare_readback: got %h expected %h", v, 32'h1234_5678);
        end
        rd(BASE + 32'd16, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL read_outside_window: got %h expected 0", v);
        end
        rd(BASE + 32'd9, v);
        checks++;
        if (v !== 32'h1234_5678) begin
            errors++;
            $display("FAIL read_low_bits_ignored: got %h expected %h", v, 32'h1234_5678);
        end
    endtask

    task automatic test_prescaled();
        bit [31:0] c, s;
        int pulses = 0;
        do_cycle(1, 0, 32'h0, 32'h0);
        do_cycle(0, 1, BASE + 32'd8, 32'd5);
        do_cycle(0, 1, BASE + 32'd0, 32'h0003_0005);
        for (int i = 1; i <= 40; i++) begin
            idle();
            if (INTR === 1'b1) pulses++;
            checks++;
            if (INTR !== m_intr) begin
                errors++;
                $display("FAIL presc_intr cyc%0d: got %b expected %b", i, INTR, m_intr);
            end
            rd(BASE + 32'd4, c);
            rd(BASE + 32'd12, s);
            checks++;
            if (c !== m_count || s !== 32'(m_match)) begin
                errors++;
                $display("FAIL presc_state cyc%0d: got count=%h match=%h expected count=%h match=%0d",
                         i, c, s, m_count, m_match);
            end
            // Ticks land every 4th cycle, so the 6th tick, at cycle 24, sees COUNT==COMPARE
            if (i == 23) begin
                checks++;
                if (c !== 32'd5 || s !== 32'd0) begin
                    errors++;
                    $display("FAIL presc_before_match: got count=%h match=%h expected count=5 match=0", c, s);
                end
            end
            if (i == 24) begin
                checks++;
                if (c !== 32'd6 || s !== 32'd1 || INTR !== 1'b1) begin
                    errors++;
                    $display("FAIL presc_at_match: got count=%h match=%h intr=%b expected 6 1 1", c, s, INTR);
                end
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL presc_pulse_count: got %0d expected 1", pulses);
        end
    endtask

    task automatic test_autoreload();
        bit [31:0] c;
        do_cycle(1, 0, 32'h0, 32'h0);
        do_cycle(0, 1, BASE + 32'd8, 32'd2);
        do_cycle(0, 1, BASE + 32'd0, 32'h0000_0007);
        for (int i = 1; i <= 12; i++) begin
            idle();
            rd(BASE + 32'd4, c);
            checks++;
            if (c !== 32'(i % 3) || INTR !== (i % 3 == 0)) begin
                errors++;
                $display("FAIL autoreload cyc%0d: got count=%h intr=%b expected count=%0d intr=%0d",
                         i, c, INTR, i % 3, (i % 3 == 0));
            end
        end
    endtask

    task automatic test_clear_vs_set();
        bit [31:0] s;
        do_cycle(1, 0, 32'h0, 32'h0);
        do_cycle(0, 1, BASE + 32'd8, 32'd2);
        do_cycle(0, 1, BASE + 32'd0, 32'h0000_0003);
        do_cycle(0, 1, BASE + 32'd4, 32'd2);
        do_cycle(0, 1, BASE + 32'd12, 32'd1);
        rd(BASE + 32'd12, s);
        checks++;
        if (s !== 32'd1) begin
            errors++;
            $display("FAIL clear_vs_set: got %h expected 1", s);
        end
        do_cycle(0, 1, BASE + 32'd0, 32'h0);
        do_cycle(0, 1, BASE + 32'd12, 32'd1);
        rd(BASE + 32'd12, s);
        checks++;
        if (s !== 32'd0) begin
            errors++;
            $display("FAIL clear_no_match: got %h expected 0", s);
        end
        do_cycle(0, 1, BASE + 32'd0, 32'h0000_0001);
        do_cycle(0, 1, BASE + 32'd4, 32'd2);
        idle();
        do_cycle(0, 1, BASE + 32'd0, 32'h0);
        do_cycle(0, 1, BASE + 32'd12, 32'h0);
        rd(BASE + 32'd12, s);
        checks++;
        if (s !== 32'd1) begin
            errors++;
            $display("FAIL write0_no_effect: got %h expected 1", s);
        end
        rd(BASE + 32'd4, s);
        checks++;
        if (s !== 32'd3) begin
            errors++;
            $display("FAIL disable_suppresses_tick: got %h expected 3", s);
        end
    endtask

    task automatic test_wrap();
        bit [31:0] c, s;
        do_cycle(1, 0, 32'h0, 32'h0);
        do_cycle(0, 1, BASE + 32'd8, 32'd5);
        do_cycle(0, 1, BASE + 32'd0, 32'h0000_0001);
        repeat (3) idle();
        do_cycle(0, 1, BASE + 32'd4, 32'hFFFF_FFFF);
        rd(BASE + 32'd4, c);
        checks++;
        if (c !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL count_write_wins: got %h expected ffffffff", c);
        end
        idle();
        rd(BASE + 32'd4, c);
        rd(BASE + 32'd12, s);
        checks++;
        if (c !== 32'h0 || s !== 32'h0) begin
            errors++;
            $display("FAIL wrap: got count=%h match=%h expected 0 0", c, s);
        end
        do_cycle(0, 1, BASE + 32'd0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            idle();
            rd(BASE + 32'd4, c);
            checks++;
            if (c !== 32'h0) begin
                errors++;
                $display("FAIL frozen cyc%0d: got %h expected 0", i, c);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit [31:0] v;
        int pulses = 0;
        do_cycle(1, 0, 32'h0, 32'h0);
        do_cycle(0, 1, BASE + 32'd8, 32'd1);
        do_cycle(0, 1, BASE + 32'd0, 32'h0000_0007);
        repeat (5) idle();
        rd(BASE + 32'd12, v);
        checks++;
        if (v !== 32'd1) begin
            errors++;
            $display("FAIL mid_match_set: got %h expected 1", v);
        end
        do_cycle(1, 0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            rd(BASE + 32'(i * 4), v);
            checks++;
            if (v !== 32'h0) begin
                errors++;
                $display("FAIL mid_reset off%0d: got %h expected 0", i, v);
            end
        end
        checks++;
        if (INTR !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_intr: got %b expected 0", INTR);
        end
        repeat (20) begin
            idle();
            if (INTR !== 1'b0) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL post_reset_pulses: got %0d expected 0", pulses);
        end
    endtask

    task automatic test_random();
        bit [31:0] v, a, d;
        bit        w, r;
        int unsigned o;
        do_cycle(1, 0, 32'h0, 32'h0);
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            w = ($urandom_range(0, 9) < 4);
            o = $urandom_range(0, 3);
            a = BASE + 32'(o * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) a = (BASE + 32'd16) | 32'($urandom_range(0, 15));
            case (o)
                0: d = {16'($urandom_range(0, 3)), 13'($urandom), 3'($urandom)} | 32'(($urandom_range(0, 4) != 0));
                1: d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3))
                                                   : 32'($urandom_range(0, 7));
                2: d = 32'($urandom_range(0, 7));
                default: d = $urandom;
            endcase
            do_cycle(r, w, a, d);
            checks++;
            if (INTR !== m_intr) begin
                errors++;
                $display("FAIL rand_intr cyc%0d: got %b expected %b", i, INTR, m_intr);
            end
            for (int k = 0; k < 4; k++) begin
                a = BASE + 32'(k * 4) + 32'($urandom_range(0, 3));
                rd(a, v);
                checks++;
                if (v !== m_read(a)) begin
                    errors++;
                    $display("FAIL rand_read cyc%0d addr %h: got %h expected %h", i, a, v, m_read(a));
                end
            end
        end
    endtask

    initial begin
        RESET      = 1'b1;
        IOBUS_WR   = 1'b0;
        IOBUS_ADDR = 32'h0;
        IOBUS_OUT  = 32'h0;
        @(negedge CLK);
        test_reset();
        test_prescaled();
        test_autoreload();
        test_clear_vs_set();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
